// File: rtl/isqrt_seq_unit.sv
// ---------------------------------------------------------------------------
// isqrt_seq_unit
//   Sequential integer square root: root_o = floor(sqrt(valor_i)).
//   Digit-by-digit restoring algorithm. Each clock consumes two operand bits
//   and produces one root bit. Every operand takes the same ROOT_W+1 cycles
//   from the accepting edge to the done_o cycle.
//
//   Optional feature macro: ISQRT_REM_EN
//     defined   : rem_o port present, rem_o = valor_i - root_o^2
//     undefined : rem_o port absent, final remainder is never stored
//
// Parameters
//   IN_W     operand width (even, >= 4)
//   ROOT_W   IN_W/2, root width (derived)
//   REM_W    ROOT_W+2, width of the shifted partial remainder (derived)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start_i  request, sampled only while ready_o=1
//   valor_i  operand, captured on the accepting edge
//   ready_o  1 while idle (start_i accepted)
//   busy_o   1 while calculating or presenting the result
//   done_o   one-cycle pulse, root_o (and rem_o) updated this cycle
//   root_o   last root, held until the next done_o
//   rem_o    last remainder (ISQRT_REM_EN only)
// ---------------------------------------------------------------------------
module isqrt_seq_unit #(
    parameter int IN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [IN_W-1:0]     valor_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [IN_W/2-1:0]   root_o
`ifdef ISQRT_REM_EN
    ,
    output logic [IN_W/2:0]     rem_o
`endif
);

    localparam int ROOT_W = IN_W / 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CNT_W  = (ROOT_W > 2) ? $clog2(ROOT_W) : 1;

    // Width of the per-step remainder result that is actually consumed.
    // Intermediate remainders never exceed ROOT_W bits; only the final one
    // needs ROOT_W+1 bits, and only when it is exported on rem_o.
`ifdef ISQRT_REM_EN
    localparam int RN_W = ROOT_W + 1;
`else
    localparam int RN_W = ROOT_W;
`endif

    generate
        if ((IN_W < 4) || ((IN_W % 2) != 0)) begin : g_bad_width
            $error("isqrt_seq_unit: IN_W must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [IN_W-1:0]    op_reg;
    logic [ROOT_W-1:0]  rem_reg;
    logic [ROOT_W-1:0]  root_acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ROOT_W-1:0]  root_o_reg;
`ifdef ISQRT_REM_EN
    logic [ROOT_W:0]    rem_o_reg;
`endif

    logic               accept;
    logic               last_step;
    logic [REM_W-1:0]   r_shift;
    logic [REM_W-1:0]   trial;
    logic               step_ge;
    logic [RN_W-1:0]    step_diff;
    logic [RN_W-1:0]    rem_next;
    logic [ROOT_W-1:0]  root_next;

    assign accept    = (state_reg == ST_IDLE) && start_i;
    assign last_step = (state_reg == ST_CALC) && (cnt_reg == '0);

    // ---------------- one restoring step ----------------
    // Bring down the next two operand bits and try to subtract 4*root+1.
    assign r_shift = {rem_reg, op_reg[IN_W-1:IN_W-2]};
    assign trial   = {root_acc_reg, 2'b01};
    // Unsigned compare: equivalent to the borrow of r_shift - trial.
    assign step_ge = (r_shift >= trial);
    // When the subtraction succeeds the true difference fits in RN_W bits,
    // so the narrow subtract is exact.
    assign step_diff = r_shift[RN_W-1:0] - trial[RN_W-1:0];
    assign rem_next  = step_ge ? step_diff : r_shift[RN_W-1:0];
    assign root_next = {root_acc_reg[ROOT_W-2:0], step_ge};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_i) state_next = ST_CALC;
            ST_CALC: if (cnt_reg == '0) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o = (state_reg == ST_IDLE);
        busy_o  = (state_reg != ST_IDLE);
        done_o  = (state_reg == ST_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            rem_reg      <= '0;
            root_acc_reg <= '0;
            cnt_reg      <= '0;
        end else if (accept) begin
            op_reg       <= valor_i;
            rem_reg      <= '0;
            root_acc_reg <= '0;
            cnt_reg      <= CNT_W'(ROOT_W - 1);
        end else if (state_reg == ST_CALC) begin
            op_reg       <= {op_reg[IN_W-3:0], 2'b00};
            // The final step's (wider) remainder is not fed back, so the
            // truncation on that last write is harmless.
            rem_reg      <= rem_next[ROOT_W-1:0];
            root_acc_reg <= root_next;
            cnt_reg      <= cnt_reg - CNT_W'(1);
        end
    end

    // Results are taken straight from the last step so they are valid in the
    // same cycle that done_o is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_o_reg <= '0;
`ifdef ISQRT_REM_EN
            rem_o_reg  <= '0;
`endif
        end else if (last_step) begin
            root_o_reg <= root_next;
`ifdef ISQRT_REM_EN
            rem_o_reg  <= rem_next;
`endif
        end
    end

    assign root_o = root_o_reg;
`ifdef ISQRT_REM_EN
    assign rem_o  = rem_o_reg;
`endif

endmodule

// File: tb/tb_isqrt_seq_unit.sv
`timescale 1ns/1ps
module tb_isqrt_seq_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start16;
    logic [15:0] valor16;
    logic        ready16, busy16, done16;
    logic [7:0]  root16;
`ifdef ISQRT_REM_EN
    logic [8:0]  rem16;
`endif

    logic        start32;
    logic [31:0] valor32;
    logic        ready32, busy32, done32;
    logic [15:0] root32;
`ifdef ISQRT_REM_EN
    logic [16:0] rem32;
`endif

    int checks   = 0;
    int failures = 0;

    isqrt_seq_unit #(.IN_W(16)) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start16),
        .valor_i (valor16),
        .ready_o (ready16),
        .busy_o  (busy16),
        .done_o  (done16),
        .root_o  (root16)
`ifdef ISQRT_REM_EN
        ,
        .rem_o   (rem16)
`endif
    );

    isqrt_seq_unit #(.IN_W(32)) u_dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start32),
        .valor_i (valor32),
        .ready_o (ready32),
        .busy_o  (busy32),
        .done_o  (done32),
        .root_o  (root32)
`ifdef ISQRT_REM_EN
        ,
        .rem_o   (rem32)
`endif
    );

    // Reference: largest r with r*r <= v, by bisection.
    function automatic void isqrt_ref(input longint unsigned v,
                                      output longint unsigned r,
                                      output longint unsigned m);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        r = lo;
        m = v - lo * lo;
    endfunction

    // Drive one 16-bit operation; lat = cycle index of done_o (1 = first
    // cycle after the accepting edge), -1 if it never came.
    task automatic do_op16(input logic [15:0] v, output int lat,
                           output logic [31:0] r, output logic [31:0] m);
        int guard;
        lat = -1; r = '0; m = '0; guard = 0;
        @(negedge clk);
        while (!ready16 && guard < 50) begin @(negedge clk); guard++; end
        start16 = 1'b1; valor16 = v;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done16) begin
                lat = c;
                r = 32'(root16);
`ifdef ISQRT_REM_EN
                m = 32'(rem16);
`endif
                break;
            end
            @(posedge clk); #1;
        end
        $display("op16 valor=%0d root=%0d rem=%0d latency=%0d", v, r, m, lat);
    endtask

    task automatic do_op32(input logic [31:0] v, output int lat,
                           output logic [31:0] r, output logic [31:0] m);
        int guard;
        lat = -1; r = '0; m = '0; guard = 0;
        @(negedge clk);
        while (!ready32 && guard < 50) begin @(negedge clk); guard++; end
        start32 = 1'b1; valor32 = v;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done32) begin
                lat = c;
                r = 32'(root32);
`ifdef ISQRT_REM_EN
                m = 32'(rem32);
`endif
                break;
            end
            @(posedge clk); #1;
        end
        $display("op32 valor=%0d root=%0d rem=%0d latency=%0d", v, r, m, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start16 = 1'b0; valor16 = '0; start32 = 1'b0; valor32 = '0;
        #22;
        checks++; if (ready16 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", ready16); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done16); end
        checks++; if (root16 !== 8'd0) begin failures++; $display("FAIL reset_root: got %0d expected 0", root16); end
`ifdef ISQRT_REM_EN
        checks++; if (rem16 !== 9'd0) begin failures++; $display("FAIL reset_rem: got %0d expected 0", rem16); end
`endif
        checks++; if (ready32 !== 1'b1) begin failures++; $display("FAIL reset_ready32: got %0b expected 1", ready32); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_zero_latency();
        int lat; logic [31:0] r, m;
        do_op16(16'd0, lat, r, m);
        checks++; if (lat != 9) begin failures++; $display("FAIL zero_latency: got %0d expected 9", lat); end
        checks++; if (r != 0) begin failures++; $display("FAIL zero_root: got %0d expected 0", r); end
`ifdef ISQRT_REM_EN
        checks++; if (m != 0) begin failures++; $display("FAIL zero_rem: got %0d expected 0", m); end
`endif
        @(posedge clk); #1;
        checks++; if (done16 !== 1'b0 || ready16 !== 1'b1) begin
            failures++; $display("FAIL done_pulse_width: got done=%0b ready=%0b expected done=0 ready=1", done16, ready16);
        end
    endtask

    task automatic test_directed16();
        // {operand, root, remainder}, worked by hand
        logic [15:0] vec_v [9] = '{16'd144, 16'd145, 16'd65535, 16'd65025, 16'd99,
                                   16'd2, 16'd3, 16'd4, 16'd1};
        int          vec_r [9] = '{12, 12, 255, 255, 9, 1, 1, 2, 1};
        int          vec_m [9] = '{0, 1, 510, 0, 18, 1, 2, 0, 0};
        int lat; logic [31:0] r, m;
        for (int i = 0; i < 9; i++) begin
            do_op16(vec_v[i], lat, r, m);
            checks++; if (lat != 9 || r != 32'(vec_r[i])) begin
                failures++; $display("FAIL root16[%0d]: valor=%0d got root=%0d lat=%0d expected root=%0d lat=9", i, vec_v[i], r, lat, vec_r[i]);
            end
`ifdef ISQRT_REM_EN
            checks++; if (m != 32'(vec_m[i])) begin
                failures++; $display("FAIL rem16[%0d]: valor=%0d got %0d expected %0d", i, vec_v[i], m, vec_m[i]);
            end
`endif
        end
        // root_o must hold after done_o
        repeat (5) @(posedge clk); #1;
        checks++; if (root16 !== 8'd1) begin failures++; $display("FAIL root_hold: got %0d expected 1", root16); end
    endtask

    task automatic test_start_ignored();
        int ndone, done_cyc, bad_ready, excl_bad;
        ndone = 0; done_cyc = -1; bad_ready = 0; excl_bad = 0;
        @(negedge clk);
        start16 = 1'b1; valor16 = 16'd100;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (done16) begin ndone++; done_cyc = c; end
            if (c <= 9 && ready16) bad_ready++;
            if (c >= 10 && !ready16) bad_ready++;
            if (ready16 == busy16) excl_bad++;
            if (c == 3) begin start16 = 1'b1; valor16 = 16'd400; end
            if (c == 4) start16 = 1'b0;
            @(posedge clk); #1;
        end
        $display("op16 valor=100 with ignored start(400): dones=%0d at cycle %0d root=%0d", ndone, done_cyc, root16);
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL ignore_done_cycle: got %0d expected 9", done_cyc); end
        checks++; if (root16 !== 8'd10) begin failures++; $display("FAIL ignore_root: got %0d expected 10", root16); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL ignore_ready_window: got %0d bad cycles expected 0", bad_ready); end
        checks++; if (excl_bad != 0) begin failures++; $display("FAIL ready_busy_exclusive: got %0d bad cycles expected 0", excl_bad); end
`ifdef ISQRT_REM_EN
        checks++; if (rem16 !== 9'd0) begin failures++; $display("FAIL ignore_rem: got %0d expected 0", rem16); end
`endif
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        @(negedge clk);
        start16 = 1'b1; valor16 = 16'd50000;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (root16 !== 8'd0) begin failures++; $display("FAIL abort_root: got %0d expected 0", root16); end
        checks++; if (ready16 !== 1'b1 || busy16 !== 1'b0) begin
            failures++; $display("FAIL abort_ready: got ready=%0b busy=%0b expected ready=1 busy=0", ready16, busy16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done16) ndone++;
        end
        $display("op16 valor=50000 aborted by reset: later dones=%0d", ndone);
        checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int ndone, guard;
        int dcyc [4];
        ndone = 0; guard = 0;
        @(negedge clk);
        start16 = 1'b1; valor16 = 16'd145;
        @(posedge clk); #1;
        for (int c = 1; c <= 32; c++) begin
            if (done16) begin
                if (ndone < 4) dcyc[ndone] = c;
                ndone++;
            end
            @(posedge clk); #1;
        end
        start16 = 1'b0;
        while (!ready16 && guard < 30) begin @(posedge clk); #1; guard++; end
        $display("back-to-back valor=145: dones=%0d root=%0d", ndone, root16);
        checks++; if (ndone != 3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
        if (ndone >= 3) begin
            checks++; if (dcyc[0] != 9) begin failures++; $display("FAIL b2b_first: got %0d expected 9", dcyc[0]); end
            checks++; if (dcyc[1] - dcyc[0] != 10 || dcyc[2] - dcyc[1] != 10) begin
                failures++; $display("FAIL b2b_spacing: got %0d,%0d expected 10,10", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
            end
        end
        checks++; if (root16 !== 8'd12) begin failures++; $display("FAIL b2b_root: got %0d expected 12", root16); end
        checks++; if (guard >= 30) begin failures++; $display("FAIL b2b_idle_timeout: got busy expected ready"); end
    endtask

    task automatic test_wide();
        logic [31:0] vec_v [3] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'd1000001};
        int          vec_r [3] = '{65535, 32768, 1000};
        int          vec_m [3] = '{131070, 0, 1};
        int lat; logic [31:0] r, m, v;
        longint unsigned er, em;
        for (int i = 0; i < 3; i++) begin
            do_op32(vec_v[i], lat, r, m);
            checks++; if (lat != 17 || r != 32'(vec_r[i])) begin
                failures++; $display("FAIL root32[%0d]: got root=%0d lat=%0d expected root=%0d lat=17", i, r, lat, vec_r[i]);
            end
`ifdef ISQRT_REM_EN
            checks++; if (m != 32'(vec_m[i])) begin
                failures++; $display("FAIL rem32[%0d]: got %0d expected %0d", i, m, vec_m[i]);
            end
`endif
        end
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            isqrt_ref(longint'(v), er, em);
            do_op32(v, lat, r, m);
            checks++; if (longint'(r) != er) begin
                failures++; $display("FAIL sweep_root32: valor=%0d got %0d expected %0d", v, r, er);
            end
`ifdef ISQRT_REM_EN
            checks++; if (longint'(m) != em) begin
                failures++; $display("FAIL sweep_rem32: valor=%0d got %0d expected %0d", v, m, em);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_directed16();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
